// File: rtl/lsu_pkg.sv
// Shared types and funct3 encodings for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {StIdle, StWait, StDone} lsu_state_e;

  typedef enum logic [1:0] {SzByte, SzHalf, SzWord} lsu_size_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Stores only know sb/sh/sw; loads also accept the unsigned encodings. Anything else is a word.
  function automatic lsu_size_e lsu_size(input logic [2:0] funct3, input logic is_store);
    lsu_size_e sz;
    sz = SzWord;
    if (is_store) begin
      if (funct3 == F3_B) sz = SzByte;
      else if (funct3 == F3_H) sz = SzHalf;
    end else begin
      if (funct3 == F3_B || funct3 == F3_BU) sz = SzByte;
      else if (funct3 == F3_H || funct3 == F3_HU) sz = SzHalf;
    end
    return sz;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational store-lane replication, byte enables, load extraction and alignment check.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic        is_store_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o,
  output logic        misaligned_o
);

  lsu_size_e   size;
  logic        sign_ext;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    size         = lsu_size(funct3_i, is_store_i);
    sign_ext     = ~funct3_i[2];
    byte_sel     = rdata_i[8*offset_i +: 8];
    half_sel     = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    be_o         = 4'b1111;
    wdata_o      = store_data_i;
    load_data_o  = rdata_i;
    misaligned_o = 1'b0;
    case (size)
      SzByte: begin
        be_o        = 4'b0001 << offset_i;
        wdata_o     = {4{store_data_i[7:0]}};
        load_data_o = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      end
      SzHalf: begin
        be_o         = offset_i[1] ? 4'b1100 : 4'b0011;
        wdata_o      = {2{store_data_i[15:0]}};
        load_data_o  = {{16{sign_ext & half_sel[15]}}, half_sel};
        misaligned_o = offset_i[0];
      end
      default: misaligned_o = |offset_i;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit: IDLE -> WAIT -> DONE handshake with the data memory.
// Define LSU_TIMEOUT_EN to abort WAIT after TIMEOUT_CYCLES with a bus-error pulse.
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned DM_ADDR_W      = 10,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic [31:0]          mem_ALUout,
  input  logic [31:0]          mem_storedata,
  input  logic                 mem_dm_rd,
  input  logic                 mem_dm_wr,
  input  logic [2:0]           mem_funct3,
  output logic [31:0]          mem_loaddata,
  output logic                 lsu_stall,
  output logic                 lsu_misaligned,
  output logic                 lsu_bus_err,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [DM_ADDR_W-1:0] dmem_addr,
  output logic [3:0]           dmem_be,
  output logic [31:0]          dmem_wdata,
  input  logic                 dmem_ready,
  input  logic [31:0]          dmem_rdata
);

  lsu_state_e state_q, state_d;

  logic                 we_q;
  logic [DM_ADDR_W-1:0] addr_q;
  logic [2:0]           funct3_q;
  logic [1:0]           offset_q;
  logic [31:0]          store_data_q;
  logic [31:0]          loaddata_q;
  logic                 misaligned_q;

  logic                 is_idle, access, issue, misaligned, completes, timeout;
  logic                 cur_we;
  logic [DM_ADDR_W-1:0] cur_addr;
  logic [2:0]           cur_funct3;
  logic [1:0]           cur_offset;
  logic [31:0]          cur_store_data;
  logic [31:0]          load_data;
  logic                 unused_addr_bits;

  assign is_idle = (state_q == StIdle);
  assign access  = mem_dm_rd | mem_dm_wr;

  // Live inputs drive the issue cycle; the captured copy keeps the bus stable through WAIT.
  assign cur_we         = is_idle ? mem_dm_wr                     : we_q;
  assign cur_addr       = is_idle ? mem_ALUout[DM_ADDR_W+1:2]     : addr_q;
  assign cur_funct3     = is_idle ? mem_funct3                    : funct3_q;
  assign cur_offset     = is_idle ? mem_ALUout[1:0]               : offset_q;
  assign cur_store_data = is_idle ? mem_storedata                 : store_data_q;

  assign unused_addr_bits = ^mem_ALUout[31:DM_ADDR_W+2];

  lsu_align u_align (
    .funct3_i     (cur_funct3),
    .is_store_i   (cur_we),
    .offset_i     (cur_offset),
    .store_data_i (cur_store_data),
    .rdata_i      (dmem_rdata),
    .be_o         (dmem_be),
    .wdata_o      (dmem_wdata),
    .load_data_o  (load_data),
    .misaligned_o (misaligned)
  );

  assign issue     = is_idle & access & ~misaligned;
  assign dmem_req  = nrst & (issue | (state_q == StWait));
  assign lsu_stall = dmem_req;
  assign dmem_we   = dmem_req & cur_we;
  assign dmem_addr = cur_addr;
  assign completes = dmem_req & dmem_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (issue) state_d = dmem_ready ? StDone : StWait;
      StWait: if (dmem_ready || timeout) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q      <= StIdle;
      loaddata_q   <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      misaligned_q <= is_idle & access & misaligned;
      if (completes && !cur_we) begin
        loaddata_q <= load_data;
      end else if ((is_idle && access && misaligned && !mem_dm_wr) || timeout) begin
        loaddata_q <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (is_idle) begin
      we_q         <= mem_dm_wr;
      addr_q       <= mem_ALUout[DM_ADDR_W+1:2];
      funct3_q     <= mem_funct3;
      offset_q     <= mem_ALUout[1:0];
      store_data_q <= mem_storedata;
    end
  end

  assign mem_loaddata   = loaddata_q;
  assign lsu_misaligned = misaligned_q;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CntW-1:0] tmo_cnt_q;
  logic            bus_err_q;

  // Count includes the current WAIT cycle, so abort happens on the TIMEOUT_CYCLES-th one.
  assign timeout = (state_q == StWait) && !dmem_ready &&
                   ((32'(tmo_cnt_q) + 32'd1) >= TIMEOUT_CYCLES);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      tmo_cnt_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= (state_q == StWait && state_d == StWait) ? tmo_cnt_q + 1'b1 : '0;
      bus_err_q <= timeout;
    end
  end

  assign lsu_bus_err = bus_err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
  assign lsu_bus_err        = 1'b0;
`endif

endmodule

// File: tb/tb_mem_lsu.sv
// Directed self-checking bench for mem_lsu; timeout steps follow LSU_TIMEOUT_EN.
module tb_mem_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        nrst;
  logic [31:0] mem_ALUout, mem_storedata, mem_loaddata, dmem_wdata, dmem_rdata;
  logic        mem_dm_rd, mem_dm_wr, lsu_stall, lsu_misaligned, lsu_bus_err;
  logic [2:0]  mem_funct3;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [9:0]  dmem_addr;
  logic [3:0]  dmem_be;

  int vectors = 0;
  int miscompares = 0;
  int n;

  always #5 clk = ~clk;

  mem_lsu #(.DM_ADDR_W(10), .TIMEOUT_CYCLES(4)) dut (
    .clk            (clk),
    .nrst           (nrst),
    .mem_ALUout     (mem_ALUout),
    .mem_storedata  (mem_storedata),
    .mem_dm_rd      (mem_dm_rd),
    .mem_dm_wr      (mem_dm_wr),
    .mem_funct3     (mem_funct3),
    .mem_loaddata   (mem_loaddata),
    .lsu_stall      (lsu_stall),
    .lsu_misaligned (lsu_misaligned),
    .lsu_bus_err    (lsu_bus_err),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_be        (dmem_be),
    .dmem_wdata     (dmem_wdata),
    .dmem_ready     (dmem_ready),
    .dmem_rdata     (dmem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called right after the issue-cycle inputs are set; returns in the first non-stalled cycle.
  task automatic run_access(input int ready_at, output int stalls);
    stalls = 0;
    for (int c = 0; c < 20; c++) begin
      dmem_ready = (c == ready_at);
      #1;
      if (!lsu_stall) break;
      stalls++;
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    nrst = 1'b0; mem_ALUout = '0; mem_storedata = '0; mem_dm_rd = 1'b0; mem_dm_wr = 1'b0;
    mem_funct3 = F3_W; dmem_ready = 1'b0; dmem_rdata = '0;

    // Reset forces req/stall low even with a pending aligned load and ready high.
    @(negedge clk); mem_dm_rd = 1'b1; dmem_ready = 1'b1; #1;
    chk("rst_req", dmem_req, 0);
    chk("rst_stall", lsu_stall, 0);
    @(negedge clk); #1;
    chk("rst_loaddata", mem_loaddata, 0);
    chk("rst_misaligned", lsu_misaligned, 0);
    chk("rst_bus_err", lsu_bus_err, 0);
    @(negedge clk); nrst = 1'b1; mem_dm_rd = 1'b0; dmem_ready = 1'b0; #1;
    chk("idle_req", dmem_req, 0);
    chk("idle_stall", lsu_stall, 0);

    // sb 0x103, ready in issue cycle
    @(negedge clk);
    mem_dm_wr = 1'b1; mem_ALUout = 32'h103; mem_storedata = 32'hA5; mem_funct3 = F3_B;
    dmem_ready = 1'b1; #1;
    chk("sb_req", dmem_req, 1);
    chk("sb_we", dmem_we, 1);
    chk("sb_addr", dmem_addr, 32'h040);
    chk("sb_be", dmem_be, 4'b1000);
    chk("sb_wdata", dmem_wdata, 32'hA5A5A5A5);
    chk("sb_stall", lsu_stall, 1);
    @(negedge clk); #1;
    chk("sb_done_req", dmem_req, 0);
    chk("sb_done_stall", lsu_stall, 0);
    @(negedge clk); mem_dm_wr = 1'b0; dmem_ready = 1'b0; #1;
    chk("sb_after_req", dmem_req, 0);

    // lb 0x002, ready on third WAIT cycle
    mem_dm_rd = 1'b1; mem_ALUout = 32'h002; mem_funct3 = F3_B; dmem_rdata = 32'h0080FF00;
    run_access(3, n);
    chk("lb_stalls", n, 4);
    chk("lb_data", mem_loaddata, 32'hFFFFFF80);
    @(negedge clk); mem_funct3 = F3_BU;
    run_access(0, n);
    chk("lbu_stalls", n, 1);
    chk("lbu_data", mem_loaddata, 32'h00000080);

    // lh misaligned
    @(negedge clk); mem_funct3 = F3_H; mem_ALUout = 32'h001; #1;
    chk("lh_mis_req", dmem_req, 0);
    chk("lh_mis_stall", lsu_stall, 0);
    @(negedge clk); mem_dm_rd = 1'b0; #1;
    chk("lh_mis_flag", lsu_misaligned, 1);
    chk("lh_mis_data", mem_loaddata, 0);
    @(negedge clk); #1;
    chk("lh_mis_pulse", lsu_misaligned, 0);

    // lw in WAIT, inputs disturbed (must hold), then reset abandons it
    mem_dm_rd = 1'b1; mem_funct3 = F3_W; mem_ALUout = 32'h008; dmem_rdata = 32'h12345678;
    #1;
    chk("lw_issue_req", dmem_req, 1);
    @(negedge clk); mem_ALUout = 32'h3FD; mem_funct3 = F3_B; #1;
    chk("lw_wait_req", dmem_req, 1);
    chk("lw_hold_addr", dmem_addr, 32'h002);
    chk("lw_hold_be", dmem_be, 4'b1111);
    @(negedge clk); nrst = 1'b0; #1;
    chk("lw_rst_req", dmem_req, 0);
    @(negedge clk); nrst = 1'b1; mem_dm_rd = 1'b0; dmem_ready = 1'b1; #1;
    chk("lw_post_rst_req", dmem_req, 0);
    chk("lw_post_rst_stall", lsu_stall, 0);
    @(negedge clk); dmem_ready = 1'b0; #1;
    chk("lw_post_rst_data", mem_loaddata, 0);

    // back-to-back sw 0x010 then lhu 0x012
    @(negedge clk);
    mem_dm_wr = 1'b1; mem_funct3 = F3_W; mem_ALUout = 32'h010; mem_storedata = 32'hCAFEF00D;
    dmem_ready = 1'b1; #1;
    chk("sw_req", dmem_req, 1);
    chk("sw_addr", dmem_addr, 32'h004);
    chk("sw_be", dmem_be, 4'b1111);
    chk("sw_wdata", dmem_wdata, 32'hCAFEF00D);
    @(negedge clk); #1;
    chk("sw_done_req", dmem_req, 0);
    @(negedge clk);
    mem_dm_wr = 1'b0; mem_dm_rd = 1'b1; mem_funct3 = F3_HU; mem_ALUout = 32'h012;
    dmem_rdata = 32'hBEEF0000; #1;
    chk("lhu_req", dmem_req, 1);
    chk("lhu_we", dmem_we, 0);
    chk("lhu_be", dmem_be, 4'b1100);
    @(negedge clk); #1;
    chk("lhu_done_req", dmem_req, 0);
    chk("lhu_data", mem_loaddata, 32'h0000BEEF);

    // rd+wr together is an sh store; must not touch mem_loaddata
    @(negedge clk);
    mem_dm_wr = 1'b1; mem_funct3 = F3_H; mem_ALUout = 32'h002; mem_storedata = 32'h1234ABCD; #1;
    chk("sh_rdwr_we", dmem_we, 1);
    chk("sh_be", dmem_be, 4'b1100);
    chk("sh_wdata", dmem_wdata, 32'hABCDABCD);
    @(negedge clk); #1;
    chk("sh_keeps_data", mem_loaddata, 32'h0000BEEF);
    // store with funct3=101 behaves as sw
    @(negedge clk);
    mem_dm_rd = 1'b0; mem_funct3 = 3'b101; mem_ALUout = 32'h00C; mem_storedata = 32'h11223344; #1;
    chk("sx_be", dmem_be, 4'b1111);
    chk("sx_wdata", dmem_wdata, 32'h11223344);
    chk("sx_addr", dmem_addr, 32'h003);

    // lh signed, one WAIT cycle
    @(negedge clk); #1;
    @(negedge clk);
    mem_dm_wr = 1'b0; mem_dm_rd = 1'b1; mem_funct3 = F3_H; mem_ALUout = 32'h000;
    dmem_rdata = 32'h00008001;
    run_access(1, n);
    chk("lh_stalls", n, 2);
    chk("lh_data", mem_loaddata, 32'hFFFF8001);

    // lw misaligned
    @(negedge clk); mem_funct3 = F3_W; mem_ALUout = 32'h006; #1;
    chk("lw_mis_req", dmem_req, 0);
    @(negedge clk); mem_dm_rd = 1'b0; #1;
    chk("lw_mis_flag", lsu_misaligned, 1);
    chk("lw_mis_data", mem_loaddata, 0);

    // plain lw, then a WAIT with no ready
    @(negedge clk); mem_dm_rd = 1'b1; mem_ALUout = 32'h020; dmem_rdata = 32'hDEADBEEF;
    run_access(0, n);
    chk("lw_stalls", n, 1);
    chk("lw_data", mem_loaddata, 32'hDEADBEEF);
    @(negedge clk); dmem_rdata = 32'h55555555;
`ifdef LSU_TIMEOUT_EN
    run_access(-1, n);
    chk("tmo_stalls", n, 5);
    chk("tmo_bus_err", lsu_bus_err, 1);
    chk("tmo_data", mem_loaddata, 0);
    @(negedge clk); mem_dm_rd = 1'b0; #1;
    chk("tmo_pulse", lsu_bus_err, 0);
`else
    run_access(10, n);
    chk("nowait_tmo_stalls", n, 11);
    chk("nowait_bus_err", lsu_bus_err, 0);
    chk("nowait_data", mem_loaddata, 32'h55555555);
    @(negedge clk); mem_dm_rd = 1'b0; #1;
`endif
    chk("end_req", dmem_req, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
